// File: rtl/led_column_fetch.sv
// led_column_fetch: fetches one LED column (WORDS_PER_COL SDRAM words) through
// the port arbiter and streams the returned words, in order, into the LED
// column buffer. Issue and receive sides are counted independently so the
// arbiter may grant and return bursts in any split.
module led_column_fetch #(
  parameter int unsigned WORDS_PER_COL = 128,
  parameter int unsigned NUM_COLS      = 128,
  parameter logic [23:0] FRAME_BASE    = 24'h000000,
  parameter int unsigned FRAME_WORDS   = 16384
) (
  input  logic                         SDRAM_CLKn,
  input  logic                         nReset,
  input  logic                         colReq,
  input  logic [$clog2(NUM_COLS)-1:0]  colIndex,
  input  logic                         frameSel,
  output logic                         readReq,
  output logic [23:0]                  address,
  input  logic                         addressAck,
  input  logic                         readDataValid,
  input  logic [15:0]                  readData,
  output logic                         LEDwren,
  output logic [$clog2(WORDS_PER_COL)-1:0] bufWrAddress,
  output logic [15:0]                  bufLedCol,
  output logic                         busy,
  output logic                         colDone,
  output logic                         overrun
);

  localparam int unsigned AW   = $clog2(WORDS_PER_COL);
  localparam int unsigned CW   = $clog2(NUM_COLS);
  localparam int unsigned CNTW = AW + 1;
  localparam logic [CNTW-1:0] TERM = CNTW'(WORDS_PER_COL);
  localparam logic [CNTW-1:0] LAST = CNTW'(WORDS_PER_COL - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [CW-1:0]     r_colIndex;
  logic              r_frameSel;
  logic [CNTW-1:0]   r_issued;
  logic [CNTW-1:0]   r_received;
  logic              r_LEDwren;
  logic [AW-1:0]     r_bufWrAddress;
  logic [15:0]       r_bufLedCol;
  logic              r_overrun;

  logic              w_readReq;
  logic              w_accept;
  logic              w_issueFire;
  logic              w_rxFire;
  logic              w_drop;
  logic [23:0]       w_bankOffset;
  logic [23:0]       w_colOffset;
  logic [23:0]       w_address;

  // Read address is built only from registered state so it holds steady
  // from the cycle readReq rises until the arbiter acknowledges it.
  always_comb begin
    w_bankOffset = r_frameSel ? 24'(FRAME_WORDS) : '0;
    w_colOffset  = 24'(r_colIndex) << AW;
    w_address    = FRAME_BASE + w_bankOffset + w_colOffset + 24'(r_issued);
  end

  // Next-state decode plus the per-cycle issue/receive/accept strobes.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_issueFire = 1'b0;
    w_rxFire    = 1'b0;
    w_readReq   = (r_state == FETCH) && (r_issued < TERM);
    w_drop      = colReq && (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (colReq) begin
          w_accept = 1'b1;
          w_next   = FETCH;
        end
      end
      FETCH: begin
        w_issueFire = w_readReq && addressAck;
        w_rxFire    = readDataValid;
        if (readDataValid && (r_received == LAST)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge SDRAM_CLKn) begin
    if (!nReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latch and the two independent issue/receive counters.
  always_ff @(posedge SDRAM_CLKn) begin
    if (!nReset) begin
      r_colIndex <= '0;
      r_frameSel <= 1'b0;
      r_issued   <= '0;
      r_received <= '0;
    end else begin
      if (w_accept) begin
        r_colIndex <= colIndex;
        r_frameSel <= frameSel;
        r_issued   <= '0;
        r_received <= '0;
      end else begin
        if (w_issueFire) begin
          r_issued <= r_issued + CNTW'(1);
        end
        if (w_rxFire) begin
          r_received <= r_received + CNTW'(1);
        end
      end
    end
  end

  // Column buffer write port: one registered write per returned word.
  always_ff @(posedge SDRAM_CLKn) begin
    if (!nReset) begin
      r_LEDwren      <= 1'b0;
      r_bufWrAddress <= '0;
      r_bufLedCol    <= '0;
    end else begin
      r_LEDwren <= w_rxFire;
      if (w_rxFire) begin
        r_bufWrAddress <= r_received[AW-1:0];
        r_bufLedCol    <= readData;
      end
    end
  end

  // Sticky flag for a column request that arrived while a fetch was running.
  always_ff @(posedge SDRAM_CLKn) begin
    if (!nReset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign readReq      = w_readReq;
  assign address      = w_address;
  assign LEDwren      = r_LEDwren;
  assign bufWrAddress = r_bufWrAddress;
  assign bufLedCol    = r_bufLedCol;
  assign busy         = (r_state != IDLE);
  assign colDone      = (r_state == DONE);
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_led_column_fetch.sv
// Bench for led_column_fetch: an arbiter model acknowledges reads and returns
// data equal to the expected address low half; expected buffer writes are
// queued when data is driven and popped when LEDwren is seen.
`timescale 1ns/1ps
module tb_led_column_fetch;

  localparam int W = 128;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        nReset, colReq, sel, frameSel, addressAck, readDataValid;
  logic [6:0]  colIndex;
  logic [15:0] readData;
  logic        colReq_a, colReq_b;

  logic        readReq_a, readReq_b, wren_a, wren_b;
  logic        busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;
  logic [23:0] addr_a, addr_b;
  logic [6:0]  bwa_a, bwa_b;
  logic [15:0] bld_a, bld_b;

  logic        m_readReq, m_wren, m_busy, m_colDone, m_overrun, o_wren;
  logic [23:0] m_address;
  logic [6:0]  m_bwa;
  logic [15:0] m_bld;

  assign colReq_a  = colReq & ~sel;
  assign colReq_b  = colReq & sel;
  assign m_readReq = sel ? readReq_b : readReq_a;
  assign m_address = sel ? addr_b : addr_a;
  assign m_wren    = sel ? wren_b : wren_a;
  assign m_bwa     = sel ? bwa_b : bwa_a;
  assign m_bld     = sel ? bld_b : bld_a;
  assign m_busy    = sel ? busy_b : busy_a;
  assign m_colDone = sel ? done_b : done_a;
  assign m_overrun = sel ? ovr_b : ovr_a;
  assign o_wren    = sel ? wren_a : wren_b;

  led_column_fetch dut_a (
    .SDRAM_CLKn(clk), .nReset(nReset), .colReq(colReq_a), .colIndex(colIndex),
    .frameSel(frameSel), .readReq(readReq_a), .address(addr_a),
    .addressAck(addressAck), .readDataValid(readDataValid), .readData(readData),
    .LEDwren(wren_a), .bufWrAddress(bwa_a), .bufLedCol(bld_a), .busy(busy_a),
    .colDone(done_a), .overrun(ovr_a)
  );

  led_column_fetch #(.FRAME_BASE(24'hFFFF80)) dut_b (
    .SDRAM_CLKn(clk), .nReset(nReset), .colReq(colReq_b), .colIndex(colIndex),
    .frameSel(frameSel), .readReq(readReq_b), .address(addr_b),
    .addressAck(addressAck), .readDataValid(readDataValid), .readData(readData),
    .LEDwren(wren_b), .bufWrAddress(bwa_b), .bufLedCol(bld_b), .busy(busy_b),
    .colDone(done_b), .overrun(ovr_b)
  );

  typedef struct { int idx; logic [15:0] data; } wr_t;
  typedef struct { logic [15:0] d; int due; } pend_t;

  wr_t   sb[$];
  pend_t pend[$];
  int    checks = 0;
  int    errors = 0;
  int    n_wr = 0;
  int    n_ack = 0;
  int    n_sent = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_addr(input bit which, input int col, input bit frame, input int i);
    logic [23:0] base;
    base = which ? 24'hFFFF80 : 24'h000000;
    return base + (frame ? 24'd16384 : 24'd0) + 24'(col * W) + 24'(i);
  endfunction

  // Scoreboard: every buffer write must match the oldest expected entry.
  always @(negedge clk) begin
    wr_t e;
    checks++;
    assert (o_wren === 1'b0) else begin
      errors++;
      $error("FAIL idle_inst_wren got=%0b exp=0", o_wren);
    end
    if (m_wren === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write got=write@%0d exp=none", m_bwa);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(m_bwa), 32'(e.idx));
        chk("wr_data", 32'(m_bld), 32'(e.data));
        n_wr++;
      end
    end
  end

  task automatic chk_reset(input string p);
    chk({p, "_readReq"}, 32'(m_readReq), 0);
    chk({p, "_address"}, 32'(m_address), sel ? 32'hFFFF80 : 32'h0);
    chk({p, "_LEDwren"}, 32'(m_wren), 0);
    chk({p, "_bufWrAddress"}, 32'(m_bwa), 0);
    chk({p, "_bufLedCol"}, 32'(m_bld), 0);
    chk({p, "_busy"}, 32'(m_busy), 0);
    chk({p, "_colDone"}, 32'(m_colDone), 0);
    chk({p, "_overrun"}, 32'(m_overrun), 0);
  endtask

  // mode 0: bursts of 8 acks, data 3 cycles after ack; mode 1: random grants
  // and return bursts of 1..8, plus stray acks once all reads are issued.
  task automatic do_fetch(input bit which, input int col, input bit frame, input int mode,
                          input int ovr_at, input int rst_at, input bit req_in_done);
    bit          done;
    bit          go;
    bit          rx;
    int          rx_burst;
    logic [23:0] ea;
    pend_t       p;
    done = 0;
    rx_burst = 0;
    @(negedge clk); #1;
    sel = which;
    colIndex = 7'(col); frameSel = frame; colReq = 1;
    n_ack = 0; n_wr = 0; n_sent = 0; pend.delete(); sb.delete();
    @(negedge clk); #1;
    colReq = 0;
    chk("busy_start", 32'(m_busy), 1);
    for (int c = 0; c < 4000 && !done; c++) begin
      addressAck = 0; readDataValid = 0; colReq = 0;
      if (m_colDone === 1'b1) begin
        chk("done_count", 32'(n_wr), W);
        chk("done_acks", 32'(n_ack), W);
        chk("done_wren", 32'(m_wren), 1);
        chk("done_busy", 32'(m_busy), 1);
        if (req_in_done) begin colReq = 1; colIndex = 7'(col + 1); end
        @(negedge clk); #1;
        colReq = 0;
        chk("post_busy", 32'(m_busy), 0);
        chk("post_colDone", 32'(m_colDone), 0);
        done = 1;
      end else begin
        chk("readReq", 32'(m_readReq), 32'(n_ack < W));
        if (rst_at > 0 && n_wr >= rst_at) begin
          nReset = 0;
          @(negedge clk); #1;
          @(negedge clk); #1;
          chk_reset("midrst");
          nReset = 1;
          pend.delete(); sb.delete();
          done = 1;
        end else begin
          rx = 0;
          if (mode == 0) begin
            if (pend.size() != 0 && pend[0].due <= c) rx = 1;
          end else begin
            if (rx_burst == 0 && $urandom_range(0, 2) == 0) rx_burst = $urandom_range(1, 8);
            if (rx_burst > 0 && pend.size() != 0) begin rx = 1; rx_burst--; end
          end
          if (rx) begin
            p = pend.pop_front();
            readDataValid = 1; readData = p.d;
            sb.push_back('{n_sent, p.d});
            n_sent++;
          end
          if (n_ack < W) begin
            go = (mode == 0) ? ((c % 12) < 8) : ($urandom_range(0, 2) != 0);
            if (go && m_readReq === 1'b1) begin
              ea = exp_addr(which, col, frame, n_ack);
              chk("address", 32'(m_address), 32'(ea));
              addressAck = 1;
              pend.push_back('{ea[15:0], c + 3});
              n_ack++;
            end
          end else if (mode == 1 && $urandom_range(0, 3) == 0) begin
            addressAck = 1;
          end
          if (c == ovr_at) begin colReq = 1; colIndex = 7'(col) ^ 7'h55; end
          @(negedge clk); #1;
        end
      end
    end
    addressAck = 0; readDataValid = 0; colReq = 0;
    chk("fetch_finished", 32'(done), 1);
  endtask

  initial begin
    nReset = 0; colReq = 0; sel = 0; frameSel = 0; colIndex = '0;
    addressAck = 0; readDataValid = 0; readData = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("rst");
    chk("rstB_address", 32'(addr_b), 32'hFFFF80);
    nReset = 1;

    // Acks while idle must not move the issue counter.
    addressAck = 1;
    repeat (3) @(negedge clk);
    #1;
    addressAck = 0;
    chk("idle_ack_readReq", 32'(m_readReq), 0);
    chk("idle_ack_address", 32'(m_address), 0);

    do_fetch(0, 3, 0, 0, -1, 0, 0);       // basic: 0x180..0x1FF
    do_fetch(0, 127, 1, 0, -1, 0, 0);     // bank 1, last column: 0x7F80..0x7FFF
    do_fetch(0, 5, 0, 1, -1, 0, 0);       // irregular grants and returns
    do_fetch(1, 0, 0, 1, -1, 0, 0);       // high base: 0xFFFF80..0xFFFFFF

    do_fetch(0, 10, 1, 1, 10, 0, 0);      // overrun mid-fetch
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("ovr_no_refetch", 32'(m_busy), 0);
      chk("ovr_sticky", 32'(m_overrun), 1);
    end

    do_fetch(0, 20, 0, 0, -1, 40, 0);     // reset after 40 words
    for (int i = 0; i < 8; i++) begin
      readDataValid = 1; readData = 16'($urandom);
      @(negedge clk); #1;
    end
    readDataValid = 0;
    @(negedge clk); #1;
    chk("stray_busy", 32'(m_busy), 0);
    chk("stray_bufWrAddress", 32'(m_bwa), 0);
    chk("stray_overrun", 32'(m_overrun), 0);
    do_fetch(0, 0, 0, 0, -1, 0, 0);       // clean fetch from address 0

    do_fetch(0, 1, 0, 1, -1, 0, 1);       // colReq in the DONE cycle
    chk("done_req_overrun", 32'(m_overrun), 1);
    repeat (3) begin
      @(negedge clk); #1;
      chk("done_req_no_fetch", 32'(m_busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
